uart_image_loader: RTL

- Input-side peripheral for the MNIST FPGA demo; it is the writer that feeds the network, where the LED checker reads the network's output.
- Receives a frame of 8-bit pixels from the host over UART (8N1, LSB first) and writes them sequentially into the network's image buffer.
- Issues a single-cycle start pulse to the network once the full frame has been written.
- Discards partial frames on framing error or inter-byte timeout.

---
 rtl/uart_image_loader.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/uart_image_loader.sv
// uart_image_loader: receives 8N1 UART bytes from the host and writes them as
// consecutive pixels into the network image buffer. A completed frame raises a
// one-cycle start pulse. A framing error or an inter-byte timeout drops the
// partial frame and raises a one-cycle frame_err pulse.
// ADDR_W must be wide enough that 2**ADDR_W >= PIXELS.
module uart_image_loader #(
  parameter int FREQUENCY      = 50000000,
  parameter int BAUD           = 115200,
  parameter int PIXELS         = 784,
  parameter int ADDR_W         = 10,
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rxd,
  input  logic              busy,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              start,
  output logic              frame_err,
  output logic              loading
);

  localparam int CPB  = FREQUENCY / BAUD;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB + 1);
  localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CW-1:0]     BIT_END  = CW'(CPB - 1);
  localparam logic [CW-1:0]     BIT_MID  = CW'(HALF);
  localparam logic [TW-1:0]     TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(PIXELS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

  rx_state_t         state;
  logic              sync1, rx_s;
  logic [CW-1:0]     baud_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shreg;
  logic              byte_vld;
  logic              stop_err;
  logic [7:0]        rx_byte;

  logic [ADDR_W-1:0] pix_cnt;
  logic [TW-1:0]     to_cnt;
  logic              last_wr;

  // Two-flop synchronizer on the asynchronous line; idles high out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rxd;
      rx_s  <= sync1;
    end
  end

  // Receive FSM: mid-bit sampling, LSB first, registered byte/error pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      byte_vld <= 1'b0;
      stop_err <= 1'b0;
      rx_byte  <= '0;
    end else begin
      byte_vld <= 1'b0;
      stop_err <= 1'b0;
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          bit_idx  <= '0;
          if (!rx_s) state <= START;
        end
        START: begin
          if (baud_cnt == BIT_MID) begin
            baud_cnt <= '0;
            // A line that is high again at mid start bit was only a glitch.
            state    <= rx_s ? IDLE : DATA;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        DATA: begin
          if (baud_cnt == BIT_END) begin
            baud_cnt <= '0;
            shreg    <= {rx_s, shreg[7:1]};
            bit_idx  <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        STOP: begin
          if (baud_cnt == BIT_END) begin
            // Leave at mid stop bit so a start bit right after is not missed.
            baud_cnt <= '0;
            state    <= IDLE;
            rx_byte  <= shreg;
            byte_vld <= rx_s;
            stop_err <= !rx_s;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Frame tracking: pixel writes, frame completion, error/timeout drop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pix_cnt   <= '0;
      to_cnt    <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      last_wr   <= 1'b0;
      start     <= 1'b0;
      frame_err <= 1'b0;
      loading   <= 1'b0;
    end else begin
      wr_en     <= 1'b0;
      last_wr   <= 1'b0;
      frame_err <= 1'b0;
      start     <= last_wr;
      loading   <= (pix_cnt != '0);
      if (byte_vld && !busy) begin
        wr_en   <= 1'b1;
        wr_addr <= pix_cnt;
        wr_data <= rx_byte;
        to_cnt  <= '0;
        if (pix_cnt == PIX_LAST) begin
          pix_cnt <= '0;
          last_wr <= 1'b1;
        end else begin
          pix_cnt <= pix_cnt + ADDR_W'(1);
        end
      end else if (stop_err) begin
        // Any stop-bit error drops the frame and is always reported.
        pix_cnt   <= '0;
        to_cnt    <= '0;
        frame_err <= 1'b1;
      end else if (pix_cnt != '0 && state == IDLE) begin
        if (to_cnt == TO_LAST) begin
          // Buffer contents stay; only the next frame restarts at address 0.
          pix_cnt   <= '0;
          to_cnt    <= '0;
          frame_err <= 1'b1;
        end else begin
          to_cnt <= to_cnt + TW'(1);
        end
      end else if (pix_cnt == '0) begin
        to_cnt <= '0;
      end
    end
  end

endmodule
